sdhc_clk_ctrl: RTL and testbench
================================

Name: sdhc_clk_ctrl

Overview:
- Generates the SD card clock (SDCLK) by sequencing the D1/D2/CE/R inputs of the SDHC double-data-rate output cell, where D1 drives the high half of C and D2 the low half.
- Supports a programmable divider, or full host rate in bypass mode.
- Starts and stops the clock glitch-free, and can hold it low for flow control.
- Emits rise/fall strobes so the CMD/DAT shifters align to SDCLK edges.
- Sits between the SDHC register file / transfer FSM and the SDCLK output cell.

Parameters:
- DIV_W, 10: width of the divider value; maximum half-period is 2^DIV_W-1 host cycles.

Ports:
- C  input  1  host clock; also clocks the output cell.
- R  input  1  reset, synchronous, active-high.
- div_i  input  DIV_W  SDCLK half-period in C cycles. 0 = bypass, SDCLK = C.
- clk_en_i  input  1  request SDCLK running (register-file enable).
- stop_req_i  input  1  flow-control pause: park SDCLK low at the next period boundary.
- oddr_d1_o  output  1  D1 to the output cell.
- oddr_d2_o  output  1  D2 to the output cell.
- oddr_ce_o  output  1  CE to the output cell.
- oddr_r_o  output  1  R to the output cell.
- sd_rise_o  output  1  one-C strobe: the D values in this cycle produce an SDCLK rising edge.
- sd_fall_o  output  1  one-C strobe: the D values in this cycle produce an SDCLK falling edge.
- running_o  output  1  state is RUN.
- clk_stable_o  output  1  at least one full SDCLK period has completed since RUN was entered.

Behaviour:
- All outputs are registered except oddr_r_o, which is a direct copy of R.
- oddr_ce_o = 1 at all times after reset, so the cell always updates.
- Reset (R=1, synchronous):
  - state = IDLE; d1 = d2 = 0; strobes = 0; running_o = 0; clk_stable_o = 0.
  - cnt = 0; phase = LOW; div_q = 0.
  - Reset asserted mid-period takes effect on the next C edge. A truncated pulse is accepted during reset only.
- States: IDLE, RUN, HOLD.
- IDLE:
  - d1 = d2 = 0.
  - If clk_en_i=1 and stop_req_i=0: latch div_q = div_i and go to RUN, starting in the high phase with cnt = 0.
  - The first cycle of RUN has d1 = d2 = 1 (N>0) and sd_rise_o = 1.
  - Transition latency: one C cycle from sampling clk_en_i.
- RUN, divided mode (div_q = N ≥ 1):
  - d1 = d2 = phase.
  - cnt runs 0..N-1 within each phase. At cnt = N-1, phase toggles and cnt = 0.
  - Each phase lasts exactly N cycles; SDCLK period = 2N cycles.
  - sd_rise_o = 1 on the first cycle of each high phase; sd_fall_o = 1 on the first cycle of each low phase.
- RUN, bypass mode (div_q = 0):
  - d1 = 1, d2 = 0 every cycle.
  - sd_rise_o = sd_fall_o = 1 every cycle.
  - The period boundary is every cycle.
- Period boundary = last cycle of a low phase (bypass: every cycle). Decisions, in priority order:
  1. clk_en_i = 0 → IDLE.
  2. stop_req_i = 1 → HOLD.
  3. Otherwise start a new period and reload div_q = div_i.
- div_i changes in mid-period are ignored until the next boundary. No runt high or low pulse shorter than min(old N, new N) ever appears.
- clk_en_i deasserted in mid-period: the current period completes (low phase included), then the block goes to IDLE.
- HOLD:
  - d1 = d2 = 0; strobes = 0; clk_stable_o stays at its value.
  - If clk_en_i = 0 → IDLE.
  - Else if stop_req_i = 0 → RUN: reload div_q, start the high phase, sd_rise_o = 1 on the next cycle.
- clk_stable_o:
  - Sets at the first period boundary after entering RUN from IDLE.
  - Clears on entry to IDLE.
  - HOLD does not clear it.
- Simultaneous clk_en_i = 0 and stop_req_i = 1 at a boundary → IDLE.
- N = 1 gives SDCLK = C/2.

Test Plan:
- Reset, then clk_en=1, div=4, stop=0:
  - d1/d2 pattern is 4 cycles of 1 then 4 cycles of 0, repeating.
  - sd_rise_o pulses every 8 cycles, starting the cycle after clk_en is sampled.
  - clk_stable_o rises after cycle 8.
- div=0 bypass:
  - d1 = 1, d2 = 0 and both strobes = 1 every cycle.
  - Switching div to 2 mid-run takes effect at the next cycle boundary: pattern 1,1,0,0.
- div=5 running, div_i changed to 2 at cnt=1 of the high phase:
  - The current period stays 5 high + 5 low.
  - The next period is 2 high + 2 low.
  - No phase shorter than 2 cycles appears.
- stop_req=1 asserted mid high phase (div=3):
  - High and low phases complete, then d = 0 and HOLD is entered.
  - Deasserting stop_req gives sd_rise_o = 1 one cycle later.
  - clk_stable_o stays 1 throughout.
- clk_en deasserted at cnt=0 of the high phase (div=3):
  - 3 high + 3 low cycles follow, then IDLE.
  - running_o and clk_stable_o = 0 after the boundary.
- R asserted mid-high phase: next cycle d1 = d2 = 0, state IDLE, all outputs at their reset values, and oddr_r_o = 1 in the same cycle.

Source files
------------

// File: rtl/sdhc_clk_ctrl.sv
// SDCLK generator driving the D1/D2/CE/R pins of a DDR output cell.
// Supports a programmable half-period divider, a bypass mode, glitch-free start/stop and a flow-control hold.
module sdhc_clk_ctrl #(
  parameter int DIV_W = 10
) (
  input  logic             C,
  input  logic             R,
  input  logic [DIV_W-1:0] div_i,
  input  logic             clk_en_i,
  input  logic             stop_req_i,
  output logic             oddr_d1_o,
  output logic             oddr_d2_o,
  output logic             oddr_ce_o,
  output logic             oddr_r_o,
  output logic             sd_rise_o,
  output logic             sd_fall_o,
  output logic             running_o,
  output logic             clk_stable_o
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  localparam logic PH_LOW  = 1'b0;
  localparam logic PH_HIGH = 1'b1;

  state_t           state;
  logic             phase;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;

  logic last_cnt, boundary, decide, go_run, go_idle, go_hold;

  assign oddr_r_o = R;

  // Bypass makes every cycle a boundary; otherwise only the last low-phase cycle.
  assign last_cnt = (cnt == div_q - DIV_W'(1));
  assign boundary = (div_q == '0) || (phase == PH_LOW && last_cnt);
  assign decide   = (state != RUN) || boundary;
  assign go_run   = decide && clk_en_i && !stop_req_i;
  assign go_idle  = decide && !clk_en_i;
  assign go_hold  = decide && clk_en_i && stop_req_i && (state != IDLE);

  always_ff @(posedge C) begin
    if (R) begin
      state        <= IDLE;
      phase        <= PH_LOW;
      cnt          <= '0;
      div_q        <= '0;
      oddr_d1_o    <= 1'b0;
      oddr_d2_o    <= 1'b0;
      oddr_ce_o    <= 1'b0;
      sd_rise_o    <= 1'b0;
      sd_fall_o    <= 1'b0;
      running_o    <= 1'b0;
      clk_stable_o <= 1'b0;
    end else begin
      oddr_ce_o <= 1'b1;
      sd_rise_o <= 1'b0;
      sd_fall_o <= 1'b0;
      if (go_run) begin
        // New period: reload divider, open with a high phase.
        state        <= RUN;
        div_q        <= div_i;
        cnt          <= '0;
        phase        <= PH_HIGH;
        running_o    <= 1'b1;
        oddr_d1_o    <= 1'b1;
        oddr_d2_o    <= (div_i != '0);
        sd_rise_o    <= 1'b1;
        sd_fall_o    <= (div_i == '0);
        clk_stable_o <= clk_stable_o | (state == RUN);
      end else if (go_idle) begin
        state        <= IDLE;
        cnt          <= '0;
        phase        <= PH_LOW;
        running_o    <= 1'b0;
        oddr_d1_o    <= 1'b0;
        oddr_d2_o    <= 1'b0;
        clk_stable_o <= 1'b0;
      end else if (go_hold) begin
        state        <= HOLD;
        cnt          <= '0;
        phase        <= PH_LOW;
        running_o    <= 1'b0;
        oddr_d1_o    <= 1'b0;
        oddr_d2_o    <= 1'b0;
        clk_stable_o <= clk_stable_o | (state == RUN);
      end else if (state == RUN) begin
        if (last_cnt) begin
          // Only the high phase can end here; the low-phase end is a boundary.
          phase     <= PH_LOW;
          cnt       <= '0;
          oddr_d1_o <= 1'b0;
          oddr_d2_o <= 1'b0;
          sd_fall_o <= 1'b1;
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sdhc_clk_ctrl.sv
// Scoreboard bench for sdhc_clk_ctrl: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_sdhc_clk_ctrl;

  localparam int DIV_W = 10;

  logic             C = 1'b0;
  logic             R = 1'b1;
  logic [DIV_W-1:0] div_i = '0;
  logic             clk_en_i = 1'b0;
  logic             stop_req_i = 1'b0;
  logic oddr_d1_o, oddr_d2_o, oddr_ce_o, oddr_r_o;
  logic sd_rise_o, sd_fall_o, running_o, clk_stable_o;

  sdhc_clk_ctrl #(.DIV_W(DIV_W)) dut (
    .C(C), .R(R), .div_i(div_i), .clk_en_i(clk_en_i), .stop_req_i(stop_req_i),
    .oddr_d1_o(oddr_d1_o), .oddr_d2_o(oddr_d2_o), .oddr_ce_o(oddr_ce_o), .oddr_r_o(oddr_r_o),
    .sd_rise_o(sd_rise_o), .sd_fall_o(sd_fall_o), .running_o(running_o), .clk_stable_o(clk_stable_o)
  );

  always #5 C = ~C;

  typedef struct {
    int       due;
    logic [6:0] v;   // {ce, d1, d2, rise, fall, running, stable}
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   done = 1'b0;

  always @(posedge C) cyc <= cyc + 1;

  // Monitor: compares every expected entry whose cycle has arrived.
  initial begin
    logic [6:0] got;
    forever begin
      @(negedge C);
      got = {oddr_ce_o, oddr_d1_o, oddr_d2_o, sd_rise_o, sd_fall_o, running_o, clk_stable_o};
      while (q.size() > 0 && q[0].due <= cyc) begin
        n_tests++;
        if (q[0].due < cyc) begin
          n_fail++;
          $display("FAIL sb_missed cycle %0d: entry for cycle %0d was never compared", cyc, q[0].due);
        end else if (got !== q[0].v) begin
          n_fail++;
          $display("FAIL out_vec cycle %0d: got %b want %b (ce,d1,d2,rise,fall,run,stable)",
                   cyc, got, q[0].v);
        end
        void'(q.pop_front());
      end
    end
  end

  // One C cycle: drive inputs, queue what the outputs must be after the next edge.
  task automatic step(input logic r, input logic en, input logic stop,
                      input logic [DIV_W-1:0] div, input logic [6:0] e);
    exp_t x;
    @(negedge C);
    R = r; clk_en_i = en; stop_req_i = stop; div_i = div;
    x.due = cyc + 1;
    x.v   = e;
    q.push_back(x);
    #1;
    n_tests++;
    if (oddr_r_o !== r) begin
      n_fail++;
      $display("FAIL oddr_r cycle %0d: got %b want %b", cyc, oddr_r_o, r);
    end
  endtask

  // n cycles of one SDCLK phase with constant inputs; strobe only on the first if 'first'.
  task automatic ph(input logic en, input logic stop, input logic [DIV_W-1:0] div,
                    input logic hi, input int n, input logic st, input logic first);
    for (int i = 0; i < n; i++)
      step(1'b0, en, stop, div,
           {1'b1, hi, hi, (i == 0) & first & hi, (i == 0) & first & ~hi, 1'b1, st});
  endtask

  initial begin
    // Reset
    step(1'b1, 1'b0, 1'b0, 10'd0, 7'b0000000);
    step(1'b1, 1'b0, 1'b0, 10'd0, 7'b0000000);

    // div=4: 4 high, 4 low; stable appears with the second period
    ph(1, 0, 10'd4, 1, 4, 0, 1);
    ph(1, 0, 10'd4, 0, 4, 0, 1);
    ph(1, 0, 10'd4, 1, 4, 1, 1);
    ph(1, 0, 10'd4, 0, 4, 1, 1);

    // Bypass: d1=1, d2=0, both strobes every cycle
    for (int i = 0; i < 4; i++) step(1'b0, 1, 0, 10'd0, 7'b1101111);
    // Back to div=2: 1,1,0,0
    ph(1, 0, 10'd2, 1, 2, 1, 1);
    ph(1, 0, 10'd2, 0, 2, 1, 1);

    // div=5 period, div_i drops to 2 mid-high: current period stays 5+5
    ph(1, 0, 10'd5, 1, 1, 1, 1);
    ph(1, 0, 10'd2, 1, 4, 1, 0);
    ph(1, 0, 10'd2, 0, 5, 1, 1);
    ph(1, 0, 10'd2, 1, 2, 1, 1);
    ph(1, 0, 10'd2, 0, 2, 1, 1);

    // div=3, stop_req raised mid-high: period completes, then HOLD
    ph(1, 0, 10'd3, 1, 1, 1, 1);
    ph(1, 1, 10'd3, 1, 2, 1, 0);
    ph(1, 1, 10'd3, 0, 3, 1, 1);
    step(1'b0, 1, 1, 10'd3, 7'b1000001);
    step(1'b0, 1, 1, 10'd3, 7'b1000001);
    step(1'b0, 1, 0, 10'd3, 7'b1111011);
    ph(1, 0, 10'd3, 1, 2, 1, 0);
    ph(1, 0, 10'd3, 0, 3, 1, 1);

    // clk_en dropped after H0 of div=3: 3 high + 3 low, then IDLE
    ph(1, 0, 10'd3, 1, 1, 1, 1);
    ph(0, 0, 10'd3, 1, 2, 1, 0);
    ph(0, 0, 10'd3, 0, 3, 1, 1);
    step(1'b0, 0, 0, 10'd3, 7'b1000000);

    // N=1 from IDLE, then clk_en=0 with stop_req=1 at the boundary -> IDLE
    step(1'b0, 1, 0, 10'd1, 7'b1111010);
    step(1'b0, 1, 0, 10'd1, 7'b1000110);
    step(1'b0, 0, 1, 10'd1, 7'b1000000);
    // stop_req in IDLE keeps it idle
    step(1'b0, 1, 1, 10'd3, 7'b1000000);

    // Reset mid-high phase
    step(1'b0, 1, 0, 10'd3, 7'b1111010);
    step(1'b0, 1, 0, 10'd3, 7'b1110010);
    step(1'b1, 1, 0, 10'd3, 7'b0000000);
    step(1'b0, 0, 0, 10'd3, 7'b1000000);

    repeat (3) @(negedge C);
    #2;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_drain: got %0d pending entries want 0", q.size());
    end
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    if (!done) begin
      $display("FAIL timeout: got no end of stimulus within 20000 time units");
      $fatal(1, "timeout");
    end
  end

endmodule
